// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one external adder among NUM_REQ requesters.
// Returns the registered sum and owner ID through a single backpressured slot.
module adder_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 4,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int CNTW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         add_a,
    output logic [DW-1:0]         add_b,
    input  logic [DW:0]           add_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW:0]           rsp_y,
    output logic [CNTW-1:0]       op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_rsp_id;
    logic [DW:0]     r_rsp_y;
    logic [CNTW-1:0] r_op_count;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic            w_can_issue;
    logic            w_grant;
    logic [IDW-1:0]  w_ptr_next;

    assign w_can_issue = !rst && ((r_state == EMPTY) || rsp_ready);
    assign w_grant     = w_found && w_can_issue;
    assign w_ptr_next  = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + IDW'(1);

    // Pick the first valid requester starting at the rr pointer, wrapping.
    always_comb begin
        logic [IDW-1:0] cand;
        w_found = 1'b0;
        w_win   = '0;
        cand    = '0;
        // Scan backwards so the closest-to-pointer hit is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(r_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    // Grant decode and adder operand steering; idle adder sees zeros.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
            add_a            = req_a[w_win*DW +: DW];
            add_b            = req_b[w_win*DW +: DW];
        end
    end

    // Response slot FSM, rr pointer and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_ptr      <= '0;
            r_rsp_id   <= '0;
            r_rsp_y    <= '0;
            r_op_count <= '0;
        end else begin
            if ((r_state == FULL) && rsp_ready) begin
                r_op_count <= r_op_count + CNTW'(1);
            end
            if (w_grant) begin
                r_state  <= FULL;
                r_rsp_y  <= add_y;
                r_rsp_id <= w_win;
                r_ptr    <= w_ptr_next;
            end else if (rsp_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign op_count  = r_op_count;

endmodule
